// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types for the register-file access controller.
// State encoding and register index constants.
package regfile_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: shares the write port and the
// rs2 read port between core writeback and a debug/host port.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int RBITS      = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_run,
  input  logic             core_wb_valid,
  input  logic [RBITS-1:0] core_wb_rd,
  input  logic [BITS-1:0]  core_wb_data,
  output logic             core_wb_ready,
  input  logic [RBITS-1:0] core_rs2,
  output logic             core_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [RBITS-1:0] dbg_addr,
  input  logic [BITS-1:0]  dbg_wdata,
  output logic             dbg_ack,
  output logic [BITS-1:0]  dbg_rdata,
  output logic             rf_run,
  output logic             rf_we,
  output logic [RBITS-1:0] rf_rd,
  output logic [BITS-1:0]  rf_rd_din,
  output logic [RBITS-1:0] rf_rs2,
  input  logic [BITS-1:0]  rf_rs2_dout
);

  localparam int SW =
    (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [RBITS-1:0] ZERO_IDX = RBITS'(REG_ZERO);

  state_t           r_state;
  logic             r_we;
  logic [RBITS-1:0] r_addr;
  logic [BITS-1:0]  r_wdata;
  logic [SW-1:0]    r_starve;
  logic             r_ack;
  logic [BITS-1:0]  r_rdata;

  logic w_pend;
  logic w_rd_grant;
  logic w_core_win;
  logic w_wr_grant;

  assign w_pend     = (r_state == ST_PEND);
  assign w_rd_grant = w_pend & ~r_we;
  // Core keeps the write port until the debug write has lost STARVE_MAX times
  assign w_core_win = w_pend & r_we & core_wb_valid
                    & (r_starve < STARVE_LIM);
  assign w_wr_grant = w_pend & r_we & ~w_core_win;

  assign rf_we         = w_wr_grant | core_wb_valid;
  assign rf_rd         = w_wr_grant ? r_addr  : core_wb_rd;
  assign rf_rd_din     = w_wr_grant ? r_wdata : core_wb_data;
  assign rf_run        = w_wr_grant | core_run;
  assign rf_rs2        = w_rd_grant ? r_addr  : core_rs2;
  assign core_wb_ready = ~w_wr_grant;
  assign core_stall    = w_rd_grant;

  assign dbg_ack   = r_ack;
  assign dbg_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_starve <= '0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_starve <= '0;
          if (dbg_req) begin
            r_we    <= dbg_we;
            r_addr  <= dbg_addr;
            r_wdata <= dbg_wdata;
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_rd_grant) begin
            r_rdata <= (r_addr == ZERO_IDX) ? '0 : rf_rs2_dout;
            r_ack   <= 1'b1;
            r_state <= ST_ACK;
          end else if (w_core_win) begin
            r_starve <= r_starve + 1'b1;
          end else begin
            r_starve <= '0;
            r_ack    <= 1'b1;
            r_state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_starve <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl with a behavioural 8x16 register file
// attached, so debug and core accesses are checked end to end.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_clr = 1'b1;
  logic        core_run = 1'b1;
  logic        core_wb_valid = 1'b0;
  logic [2:0]  core_wb_rd = '0;
  logic [15:0] core_wb_data = '0;
  logic        core_wb_ready;
  logic [2:0]  core_rs2 = '0;
  logic        core_stall;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;
  logic        rf_run;
  logic        rf_we;
  logic [2:0]  rf_rd;
  logic [15:0] rf_rd_din;
  logic [2:0]  rf_rs2;
  logic [15:0] rf_rs2_dout;

  logic [15:0] regs [8];
  logic [15:0] sb_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(
    .BITS(16), .RBITS(3), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core_run(core_run),
    .core_wb_valid(core_wb_valid), .core_wb_rd(core_wb_rd),
    .core_wb_data(core_wb_data), .core_wb_ready(core_wb_ready),
    .core_rs2(core_rs2), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .rf_run(rf_run), .rf_we(rf_we), .rf_rd(rf_rd),
    .rf_rd_din(rf_rd_din), .rf_rs2(rf_rs2), .rf_rs2_dout(rf_rs2_dout)
  );

  // Register file: r0 reads zero and ignores writes; run gates writes
  always_ff @(posedge clk) begin
    if (tb_clr) begin
      for (int k = 0; k < 8; k++) regs[k] <= '0;
    end else if (rf_run && rf_we && rf_rd != 3'd0) begin
      regs[rf_rd] <= rf_rd_din;
    end
  end
  assign rf_rs2_dout = (rf_rs2 == 3'd0) ? 16'h0 : regs[rf_rs2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_op(input logic we, input logic [2:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_rd,
                        output int lat, output int n_stall,
                        output int n_nrdy, output int n_run);
    logic [15:0] e;
    lat = -1; n_stall = 0; n_nrdy = 0; n_run = 0;
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    sb_q.push_back(exp_rd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        dbg_we = ~we; dbg_addr = ~addr; dbg_wdata = ~wd;
      end
      n_stall += int'(core_stall);
      n_nrdy  += int'(!core_wb_ready);
      n_run   += int'(rf_run);
      if (dbg_ack) begin
        lat = i;
        break;
      end
    end
    dbg_req = 1'b0;
    e = sb_q.pop_front();
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $error("FAIL ack_timeout: observed no ack expected ack within 20 cycles");
    end else begin
      chk("dbg_rdata", {16'h0, dbg_rdata}, {16'h0, e});
    end
  endtask

  task automatic core_read(input string tag, input logic [2:0] a,
                           input logic [15:0] exp);
    @(negedge clk);
    core_rs2 = a;
    #1;
    chk(tag, {16'h0, rf_rs2_dout}, {16'h0, exp});
  endtask

  task automatic cwrite(input logic [2:0] rd, input logic [15:0] d);
    @(posedge clk); #1;
    core_wb_valid = 1'b1; core_wb_rd = rd; core_wb_data = d;
    @(posedge clk); #1;
    core_wb_valid = 1'b0;
  endtask

  initial begin
    int lat, ns, nn, nr, acks;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; tb_clr = 1'b0;
    @(negedge clk);
    chk("rst_ack", 32'(dbg_ack), 32'd0);
    chk("rst_rdata", 32'(dbg_rdata), 32'd0);
    chk("rst_ready", 32'(core_wb_ready), 32'd1);
    chk("rst_stall", 32'(core_stall), 32'd0);

    cwrite(3'd5, 16'h1234);
    dbg_op(1'b0, 3'd5, 16'h0, 16'h1234, lat, ns, nn, nr);
    chk("rd5_lat", lat, 32'd2);
    chk("rd5_stall", ns, 32'd1);

    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3'd3;
    @(posedge clk); #1;
    chk("abort_pend_stall", 32'(core_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(dbg_ack), 32'd0);
    chk("abort_rdata", 32'(dbg_rdata), 32'd0);
    @(negedge clk);
    dbg_req = 1'b0; rst_n = 1'b1;
    core_wb_valid = 1'b1; core_wb_rd = 3'd2; core_wb_data = 16'h0A0A;
    #1;
    chk("abort_rf_we1", 32'(rf_we), 32'd1);
    chk("abort_rf_rd", 32'(rf_rd), 32'd2);
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      acks += int'(dbg_ack);
    end
    chk("abort_no_ack", acks, 32'd0);
    core_wb_valid = 1'b0;
    #1;
    chk("abort_rf_we0", 32'(rf_we), 32'd0);

    dbg_op(1'b1, 3'd3, 16'hBEEF, 16'h0000, lat, ns, nn, nr);
    chk("wr3_lat", lat, 32'd2);
    core_read("core_rd3", 3'd3, 16'hBEEF);

    core_wb_valid = 1'b1; core_wb_rd = 3'd2; core_wb_data = 16'h5555;
    dbg_op(1'b0, 3'd5, 16'h0, 16'h1234, lat, ns, nn, nr);
    chk("rdpar_lat", lat, 32'd2);
    chk("rdpar_stall", ns, 32'd1);
    chk("rdpar_nrdy", nn, 32'd0);
    core_wb_valid = 1'b0;
    core_read("core_rd2", 3'd2, 16'h5555);

    core_wb_valid = 1'b1; core_wb_rd = 3'd6; core_wb_data = 16'h0606;
    dbg_op(1'b1, 3'd4, 16'hCAFE, 16'h1234, lat, ns, nn, nr);
    chk("starve_lat", lat, 32'd5);
    chk("starve_nrdy", nn, 32'd1);
    chk("starve_stall", ns, 32'd0);
    core_wb_valid = 1'b0;
    core_read("core_rd4", 3'd4, 16'hCAFE);
    core_read("core_rd6", 3'd6, 16'h0606);

    core_run = 1'b0;
    cwrite(3'd1, 16'h1111);
    dbg_op(1'b1, 3'd7, 16'h00A5, 16'h1234, lat, ns, nn, nr);
    chk("halt_lat", lat, 32'd2);
    chk("halt_run_cycles", nr, 32'd1);
    core_run = 1'b1;
    core_read("core_rd7", 3'd7, 16'h00A5);
    core_read("core_rd1_blocked", 3'd1, 16'h0000);

    dbg_op(1'b1, 3'd0, 16'hFFFF, 16'h1234, lat, ns, nn, nr);
    chk("wr0_lat", lat, 32'd2);
    dbg_op(1'b0, 3'd0, 16'h0, 16'h0000, lat, ns, nn, nr);
    chk("rd0_lat", lat, 32'd2);
    core_read("core_rd0", 3'd0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish by 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
